// File: rtl/uart_frame_link_if.sv
// Payload-side handshake between the framed UART link and the command/config logic.
// The master is the host logic; the slave is the link itself.
interface uart_frame_link_if #(
    parameter int PAYLOAD_BYTES = 8
);
    logic [8*PAYLOAD_BYTES-1:0] rx_data;
    logic                       rx_valid;
    logic                       rx_err;
    logic [8*PAYLOAD_BYTES-1:0] tx_data;
    logic                       tx_valid;
    logic                       tx_ready;

    modport master (input rx_data, rx_valid, rx_err, tx_ready, output tx_data, tx_valid);
    modport slave  (output rx_data, rx_valid, rx_err, tx_ready, input tx_data, tx_valid);
endinterface

// File: rtl/uart_frame_link.sv
// Full-duplex framed RS232 link: SOF + fixed-length payload + EOF in both directions,
// with RX inter-byte timeout and stop-bit checking. RX and TX share nothing but the clock.
module uart_frame_link #(
    parameter int         CLK_DIV       = 173,
    parameter int         PAYLOAD_BYTES = 8,
    parameter logic [7:0] SOF           = 8'hC0,
    parameter logic [7:0] EOF           = 8'hCF,
    parameter int         TIMEOUT_CYC   = 3820
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              uart_rx_i,
    output logic              uart_tx_o,
    uart_frame_link_if.slave  bus
);
    localparam int DW    = 8*PAYLOAD_BYTES;
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BC_W  = $clog2(PAYLOAD_BYTES+2);
    localparam int TO_W  = $clog2(TIMEOUT_CYC+1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV-1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV/2-1);

    localparam logic [1:0] RB_IDLE = 2'd0, RB_START = 2'd1, RB_DATA = 2'd2, RB_STOP = 2'd3;
    localparam logic [1:0] F_HUNT = 2'd0, F_PAY = 2'd1, F_CHK = 2'd2;
    localparam logic       T_IDLE = 1'b0, T_SHIFT = 1'b1;

    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    logic [1:0]       rb_state_q, rb_state_d;
    logic [DIV_W-1:0] rb_div_q, rb_div_d;
    logic [2:0]       rb_bit_q, rb_bit_d;
    logic [7:0]       rb_sh_q, rb_sh_d;
    logic             byte_done, byte_ok;

    logic [1:0]       f_state_q, f_state_d;
    logic [BC_W-1:0]  f_cnt_q, f_cnt_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic [DW-1:0]    hold_q, hold_d, rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d, rx_err_q, rx_err_d;

    logic             tx_state_q, tx_state_d;
    logic [DIV_W-1:0] tx_div_q, tx_div_d;
    logic [3:0]       tx_bit_q, tx_bit_d;
    logic [BC_W-1:0]  tx_byte_q, tx_byte_d;
    logic [DW-1:0]    tx_pay_q, tx_pay_d;
    logic             tx_line_q, tx_line_d;
    logic [7:0]       cur_byte;

    // Byte engine: byte_done marks the stop-bit sample edge, rb_sh_q holds the byte.
    always_comb begin
        rb_state_d = rb_state_q;
        rb_div_d   = rb_div_q + 1'b1;
        rb_bit_d   = rb_bit_q;
        rb_sh_d    = rb_sh_q;
        byte_done  = 1'b0;
        byte_ok    = 1'b0;
        case (rb_state_q)
            RB_IDLE: begin
                rb_div_d = '0;
                if (rx_prev_q && !rx_sync_q) rb_state_d = RB_START;
            end
            RB_START: if (rb_div_q == DIV_HALF) begin
                rb_div_d   = '0;
                rb_bit_d   = '0;
                rb_state_d = rx_sync_q ? RB_IDLE : RB_DATA;
            end
            RB_DATA: if (rb_div_q == DIV_LAST) begin
                rb_div_d = '0;
                rb_sh_d  = {rx_sync_q, rb_sh_q[7:1]};
                rb_bit_d = rb_bit_q + 1'b1;
                if (rb_bit_q == 3'd7) rb_state_d = RB_STOP;
            end
            default: if (rb_div_q == DIV_LAST) begin
                byte_done  = 1'b1;
                byte_ok    = rx_sync_q;
                rb_state_d = RB_IDLE;
            end
        endcase
    end

    always_comb begin
        f_state_d  = f_state_q;
        f_cnt_d    = f_cnt_q;
        to_d       = '0;
        hold_d     = hold_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_err_d   = 1'b0;
        case (f_state_q)
            F_HUNT: if (byte_done && byte_ok && rb_sh_q == SOF) begin
                f_state_d = F_PAY;
                f_cnt_d   = '0;
            end
            default: begin
                to_d = to_q + 1'b1;
                if (byte_done) begin
                    to_d = '0;
                    if (!byte_ok) begin
                        rx_err_d  = 1'b1;
                        f_state_d = F_HUNT;
                    end else if (f_state_q == F_PAY) begin
                        hold_d  = (hold_q << 8) | DW'(rb_sh_q);
                        f_cnt_d = f_cnt_q + 1'b1;
                        if (f_cnt_q == BC_W'(PAYLOAD_BYTES-1)) f_state_d = F_CHK;
                    end else begin
                        if (rb_sh_q == EOF) begin
                            rx_data_d  = hold_q;
                            rx_valid_d = 1'b1;
                        end else begin
                            rx_err_d = 1'b1;
                        end
                        f_state_d = F_HUNT;
                    end
                end else if (to_q == TO_W'(TIMEOUT_CYC-1)) begin
                    rx_err_d  = 1'b1;
                    f_state_d = F_HUNT;
                end
            end
        endcase
    end

    // Payload bytes come from the top of tx_pay_q, which shifts after each one is sent.
    assign cur_byte = (tx_byte_q == '0) ? SOF :
                      (tx_byte_q == BC_W'(PAYLOAD_BYTES+1)) ? EOF : tx_pay_q[DW-1 -: 8];

    always_comb begin
        tx_state_d = tx_state_q;
        tx_div_d   = tx_div_q;
        tx_bit_d   = tx_bit_q;
        tx_byte_d  = tx_byte_q;
        tx_pay_d   = tx_pay_q;
        tx_line_d  = tx_line_q;
        if (tx_state_q == T_IDLE) begin
            if (bus.tx_valid) begin
                tx_state_d = T_SHIFT;
                tx_pay_d   = bus.tx_data;
                tx_div_d   = '0;
                tx_bit_d   = '0;
                tx_byte_d  = '0;
                tx_line_d  = 1'b0;
            end
        end else begin
            tx_div_d = tx_div_q + 1'b1;
            if (tx_div_q == DIV_LAST) begin
                tx_div_d = '0;
                if (tx_bit_q == 4'd9) begin
                    tx_bit_d = '0;
                    if (tx_byte_q == BC_W'(PAYLOAD_BYTES+1)) begin
                        tx_state_d = T_IDLE;
                        tx_line_d  = 1'b1;
                    end else begin
                        tx_byte_d = tx_byte_q + 1'b1;
                        tx_line_d = 1'b0;
                        if (tx_byte_q != '0) tx_pay_d = tx_pay_q << 8;
                    end
                end else begin
                    tx_bit_d  = tx_bit_q + 1'b1;
                    tx_line_d = (tx_bit_q == 4'd8) ? 1'b1 : cur_byte[tx_bit_q[2:0]];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rb_state_q <= RB_IDLE;
            rb_div_q   <= '0;
            rb_bit_q   <= '0;
            rb_sh_q    <= '0;
            f_state_q  <= F_HUNT;
            f_cnt_q    <= '0;
            to_q       <= '0;
            hold_q     <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            tx_state_q <= T_IDLE;
            tx_div_q   <= '0;
            tx_bit_q   <= '0;
            tx_byte_q  <= '0;
            tx_pay_q   <= '0;
            tx_line_q  <= 1'b1;
        end else begin
            rx_meta_q  <= uart_rx_i;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rb_state_q <= rb_state_d;
            rb_div_q   <= rb_div_d;
            rb_bit_q   <= rb_bit_d;
            rb_sh_q    <= rb_sh_d;
            f_state_q  <= f_state_d;
            f_cnt_q    <= f_cnt_d;
            to_q       <= to_d;
            hold_q     <= hold_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_err_q   <= rx_err_d;
            tx_state_q <= tx_state_d;
            tx_div_q   <= tx_div_d;
            tx_bit_q   <= tx_bit_d;
            tx_byte_q  <= tx_byte_d;
            tx_pay_q   <= tx_pay_d;
            tx_line_q  <= tx_line_d;
        end
    end

    assign uart_tx_o    = tx_line_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_err   = rx_err_q;
    assign bus.tx_ready = (tx_state_q == T_IDLE);
endmodule

// File: tb/tb_uart_frame_link.sv
// Bench for uart_frame_link: serial RX stimulus, TX decoded by a behavioural receiver,
// scoreboard queues for received payloads and transmitted bytes.
module tb_uart_frame_link;
    localparam int CLK_DIV = 16;
    localparam int PB      = 8;
    localparam int TO      = 400;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic uart_rx = 1'b1;
    logic uart_tx;

    uart_frame_link_if #(.PAYLOAD_BYTES(PB)) bus();

    uart_frame_link #(
        .CLK_DIV(CLK_DIV), .PAYLOAD_BYTES(PB), .SOF(8'hC0), .EOF(8'hCF), .TIMEOUT_CYC(TO)
    ) dut (
        .clk_i(clk), .rst_i(rst), .uart_rx_i(uart_rx), .uart_tx_o(uart_tx), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int err_cnt = 0;
    int val_cnt = 0;
    logic [63:0] exp_rx[$];
    logic [63:0] got_rx[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  got_tx[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rx_valid === 1'b1) begin
                got_rx.push_back(bus.rx_data);
                val_cnt++;
            end
            if (bus.rx_err === 1'b1) err_cnt++;
        end
    end

    // Behavioural receiver on the looped-back TX line; 8'hEE marks a bad stop bit.
    initial begin : tx_model
        logic [7:0] b;
        forever begin
            wait (uart_tx === 1'b1);
            wait (uart_tx === 1'b0);
            repeat (CLK_DIV/2) @(negedge clk);
            if (uart_tx === 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (CLK_DIV) @(negedge clk);
                    b[i] = uart_tx;
                end
                repeat (CLK_DIV) @(negedge clk);
                got_tx.push_back(uart_tx === 1'b1 ? b : 8'hEE);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CLK_DIV) @(negedge clk);
        end
        uart_rx = stop_ok;
        repeat (CLK_DIV) @(negedge clk);
        uart_rx = 1'b1;
        if (!stop_ok) repeat (2*CLK_DIV) @(negedge clk);
    endtask

    task automatic send_frame(input logic [63:0] d);
        send_byte(8'hC0, 1'b1);
        for (int i = 0; i < PB; i++) send_byte(d[63-8*i -: 8], 1'b1);
        send_byte(8'hCF, 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (uart_tx !== 1'b1) begin n_bad++; $display("FAIL reset_uart_tx: got %b expected 1", uart_tx); end
        n_cmp++; if (bus.tx_ready !== 1'b1) begin n_bad++; $display("FAIL reset_tx_ready: got %b expected 1", bus.tx_ready); end
        n_cmp++; if (bus.rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rx_valid: got %b expected 0", bus.rx_valid); end
        n_cmp++; if (bus.rx_err !== 1'b0) begin n_bad++; $display("FAIL reset_rx_err: got %b expected 0", bus.rx_err); end
        n_cmp++; if (bus.rx_data !== 64'h0) begin n_bad++; $display("FAIL reset_rx_data: got %h expected 0", bus.rx_data); end
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_rx_good();
        int e0;
        logic [63:0] e, g;
        e0 = err_cnt;
        exp_rx.push_back(64'h0102030405060708);
        send_frame(64'h0102030405060708);
        repeat (40) @(negedge clk);
        n_cmp++; if (got_rx.size() != exp_rx.size()) begin n_bad++; $display("FAIL good_rx_count: got %0d expected %0d", got_rx.size(), exp_rx.size()); end
        while (exp_rx.size() > 0 && got_rx.size() > 0) begin
            e = exp_rx.pop_front(); g = got_rx.pop_front();
            n_cmp++; if (g !== e) begin n_bad++; $display("FAIL good_rx_data: got %h expected %h", g, e); end
        end
        n_cmp++; if (err_cnt - e0 != 0) begin n_bad++; $display("FAIL good_rx_err: got %0d expected 0", err_cnt - e0); end
        exp_rx.delete(); got_rx.delete();
    endtask

    task automatic test_junk();
        int e0;
        logic [63:0] e, g;
        e0 = err_cnt;
        send_byte(8'h55, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hCF, 1'b1);
        exp_rx.push_back(64'h0102030405060708);
        send_frame(64'h0102030405060708);
        repeat (40) @(negedge clk);
        n_cmp++; if (got_rx.size() != exp_rx.size()) begin n_bad++; $display("FAIL junk_rx_count: got %0d expected %0d", got_rx.size(), exp_rx.size()); end
        while (exp_rx.size() > 0 && got_rx.size() > 0) begin
            e = exp_rx.pop_front(); g = got_rx.pop_front();
            n_cmp++; if (g !== e) begin n_bad++; $display("FAIL junk_rx_data: got %h expected %h", g, e); end
        end
        n_cmp++; if (err_cnt - e0 != 0) begin n_bad++; $display("FAIL junk_rx_err: got %0d expected 0", err_cnt - e0); end
        exp_rx.delete(); got_rx.delete();
    endtask

    task automatic test_bad_eof();
        int e0;
        logic [63:0] e, g;
        e0 = err_cnt;
        send_byte(8'hC0, 1'b1);
        for (int i = 1; i <= PB; i++) send_byte(8'(i), 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (10) @(negedge clk);
        n_cmp++; if (got_rx.size() != 0) begin n_bad++; $display("FAIL bad_eof_no_valid: got %0d expected 0", got_rx.size()); end
        exp_rx.push_back(64'h1122334455667788);
        send_frame(64'h1122334455667788);
        repeat (40) @(negedge clk);
        n_cmp++; if (err_cnt - e0 != 1) begin n_bad++; $display("FAIL bad_eof_err: got %0d expected 1", err_cnt - e0); end
        n_cmp++; if (got_rx.size() != exp_rx.size()) begin n_bad++; $display("FAIL bad_eof_rx_count: got %0d expected %0d", got_rx.size(), exp_rx.size()); end
        while (exp_rx.size() > 0 && got_rx.size() > 0) begin
            e = exp_rx.pop_front(); g = got_rx.pop_front();
            n_cmp++; if (g !== e) begin n_bad++; $display("FAIL bad_eof_rx_data: got %h expected %h", g, e); end
        end
        exp_rx.delete(); got_rx.delete();
    endtask

    task automatic test_timeout();
        int e0, v0, dt;
        e0 = err_cnt; v0 = val_cnt;
        send_byte(8'hC0, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        // Sender returns ~5 cycles after the DUT samples the stop bit of 0x33.
        dt = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            dt++;
            if (err_cnt != e0) break;
        end
        n_cmp++; if (dt < 388 || dt > 402) begin n_bad++; $display("FAIL timeout_latency: got %0d cycles expected about %0d", dt, TO - 5); end
        repeat (500 - dt) @(negedge clk);
        n_cmp++; if (err_cnt - e0 != 1) begin n_bad++; $display("FAIL timeout_err_count: got %0d expected 1", err_cnt - e0); end
        n_cmp++; if (val_cnt != v0) begin n_bad++; $display("FAIL timeout_no_valid: got %0d expected %0d", val_cnt, v0); end
        n_cmp++; if (bus.rx_data !== 64'h1122334455667788) begin n_bad++; $display("FAIL timeout_rx_data: got %h expected 1122334455667788", bus.rx_data); end
        got_rx.delete();
    endtask

    task automatic test_stop_err();
        int e0, v0, e1;
        logic [63:0] e, g;
        e0 = err_cnt; v0 = val_cnt;
        send_byte(8'hC0, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h04, 1'b0);
        for (int i = 5; i <= PB; i++) send_byte(8'(i), 1'b1);
        send_byte(8'hCF, 1'b1);
        repeat (50) @(negedge clk);
        n_cmp++; if (err_cnt - e0 != 1) begin n_bad++; $display("FAIL stop_err_count: got %0d expected 1", err_cnt - e0); end
        n_cmp++; if (val_cnt != v0) begin n_bad++; $display("FAIL stop_err_no_valid: got %0d expected %0d", val_cnt, v0); end
        e1 = err_cnt;
        uart_rx = 1'b0;
        repeat (30) @(negedge clk);
        uart_rx = 1'b1;
        repeat (300) @(negedge clk);
        n_cmp++; if (err_cnt != e1 || val_cnt != v0) begin n_bad++; $display("FAIL glitch_quiet: got err %0d valid %0d expected err %0d valid %0d", err_cnt, val_cnt, e1, v0); end
        // SOF/EOF values inside the payload are ordinary data.
        got_rx.delete();
        exp_rx.push_back(64'hC0CFC0CF01020304);
        send_frame(64'hC0CFC0CF01020304);
        repeat (40) @(negedge clk);
        n_cmp++; if (got_rx.size() != exp_rx.size()) begin n_bad++; $display("FAIL plain_data_count: got %0d expected %0d", got_rx.size(), exp_rx.size()); end
        while (exp_rx.size() > 0 && got_rx.size() > 0) begin
            e = exp_rx.pop_front(); g = got_rx.pop_front();
            n_cmp++; if (g !== e) begin n_bad++; $display("FAIL plain_data_rx: got %h expected %h", g, e); end
        end
        exp_rx.delete(); got_rx.delete();
    endtask

    task automatic test_tx();
        logic [63:0] d, e, g;
        logic [7:0] eb, gb;
        int lowcnt;
        d = 64'hDEADBEEFCAFEF00D;
        got_tx.delete();
        exp_tx.push_back(8'hC0);
        for (int i = 0; i < PB; i++) exp_tx.push_back(d[63-8*i -: 8]);
        exp_tx.push_back(8'hCF);
        exp_rx.push_back(64'hA5A55A5A0F0FF0F0);
        fork
            send_frame(64'hA5A55A5A0F0FF0F0);
            begin
                @(negedge clk);
                bus.tx_data  = d;
                bus.tx_valid = 1'b1;
                @(negedge clk);
                bus.tx_valid = 1'b0;
                bus.tx_data  = 64'h0;
                lowcnt = 0;
                for (int i = 0; i < 3000; i++) begin
                    if (bus.tx_ready === 1'b1) break;
                    lowcnt++;
                    if (i == 500) begin bus.tx_data = 64'h1111111111111111; bus.tx_valid = 1'b1; end
                    if (i == 501) bus.tx_valid = 1'b0;
                    @(negedge clk);
                end
                bus.tx_valid = 1'b0;
                n_cmp++; if (lowcnt != (PB+2)*10*CLK_DIV) begin n_bad++; $display("FAIL tx_ready_low: got %0d expected %0d", lowcnt, (PB+2)*10*CLK_DIV); end
            end
        join
        repeat (60) @(negedge clk);
        n_cmp++; if (got_tx.size() != exp_tx.size()) begin n_bad++; $display("FAIL tx_byte_count: got %0d expected %0d", got_tx.size(), exp_tx.size()); end
        while (exp_tx.size() > 0 && got_tx.size() > 0) begin
            eb = exp_tx.pop_front(); gb = got_tx.pop_front();
            n_cmp++; if (gb !== eb) begin n_bad++; $display("FAIL tx_byte: got %h expected %h", gb, eb); end
        end
        n_cmp++; if (got_rx.size() != exp_rx.size()) begin n_bad++; $display("FAIL duplex_rx_count: got %0d expected %0d", got_rx.size(), exp_rx.size()); end
        while (exp_rx.size() > 0 && got_rx.size() > 0) begin
            e = exp_rx.pop_front(); g = got_rx.pop_front();
            n_cmp++; if (g !== e) begin n_bad++; $display("FAIL duplex_rx_data: got %h expected %h", g, e); end
        end
        exp_tx.delete(); got_tx.delete(); exp_rx.delete(); got_rx.delete();
    endtask

    task automatic test_tx_reset();
        int e0;
        e0 = err_cnt;
        fork
            begin
                send_byte(8'hC0, 1'b1);
                send_byte(8'h11, 1'b1);
                send_byte(8'h22, 1'b1);
            end
            begin
                @(negedge clk);
                bus.tx_data  = 64'h0123456789ABCDEF;
                bus.tx_valid = 1'b1;
                @(negedge clk);
                bus.tx_valid = 1'b0;
                repeat (300) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                n_cmp++; if (uart_tx !== 1'b1) begin n_bad++; $display("FAIL rst_mid_uart_tx: got %b expected 1", uart_tx); end
                n_cmp++; if (bus.tx_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_tx_ready: got %b expected 1", bus.tx_ready); end
                n_cmp++; if (bus.rx_data !== 64'h0) begin n_bad++; $display("FAIL rst_mid_rx_data: got %h expected 0", bus.rx_data); end
                rst = 1'b0;
            end
        join
        repeat (600) @(negedge clk);
        n_cmp++; if (err_cnt != e0) begin n_bad++; $display("FAIL rst_mid_no_err: got %0d expected %0d", err_cnt, e0); end
        got_tx.delete(); got_rx.delete();
    endtask

    initial begin
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        test_reset();
        test_rx_good();
        test_junk();
        test_bad_eof();
        test_timeout();
        test_stop_err();
        test_tx();
        test_tx_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
